// File: rtl/i3c_pkg.sv
// ============================================================================
// Module  : i3c_pkg
// Brief   : Shared types for the I3C multi-agent bus model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package i3c_pkg;

  typedef enum logic [0:0] {
    FREE = 1'b0,
    BUSY = 1'b1
  } bus_state_e;

endpackage

`default_nettype wire

// File: rtl/i3c_bus_line_sync.sv
// ============================================================================
// Module  : i3c_bus_line_sync
// Brief   : Reset-to-1 synchroniser chain for one bus line, with edge outputs.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module i3c_bus_line_sync #(
  parameter int unsigned SyncStages = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic line_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SyncStages-1:0] sync_q, sync_d;
  logic                  prev_q;

  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = line_i;
    for (int i = 1; i < int'(SyncStages); i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= sync_d;
      prev_q <= sync_q[SyncStages-1];
    end
  end

  assign sync_o = sync_q[SyncStages-1];
  assign rise_o = sync_q[SyncStages-1] & ~prev_q;
  assign fall_o = ~sync_q[SyncStages-1] & prev_q;

endmodule

`default_nettype wire

// File: rtl/i3c_multi_agent_bus.sv
// ============================================================================
// Module  : i3c_multi_agent_bus
// Brief   : Open-drain SCL/SDA resolution for N agents plus bus-condition,
//           idle-timing, contention and arbitration-loss monitoring.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module i3c_multi_agent_bus
  import i3c_pkg::*;
#(
  parameter int unsigned NumAgents    = 2,
  parameter int unsigned SyncStages   = 2,
  parameter int unsigned TimerWidth   = 16,
  parameter int unsigned ContCntWidth = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NumAgents-1:0]    agent_scl_i,
  input  logic [NumAgents-1:0]    agent_scl_en_i,
  input  logic [NumAgents-1:0]    agent_sda_i,
  input  logic [NumAgents-1:0]    agent_sda_en_i,
  output logic                    scl_o,
  output logic                    sda_o,
  output logic                    scl_sync_o,
  output logic                    sda_sync_o,
  input  logic [TimerWidth-1:0]   t_buf_i,
  input  logic [TimerWidth-1:0]   t_idle_i,
  output logic                    start_det_o,
  output logic                    rstart_det_o,
  output logic                    stop_det_o,
  output logic                    bus_busy_o,
  output logic                    bus_free_o,
  output logic                    bus_idle_o,
  output logic                    event_contention_o,
  output logic [ContCntWidth-1:0] contention_cnt_o,
  input  logic                    contention_cnt_clr_i,
  output logic [NumAgents-1:0]    arb_lost_o
);

  logic scl_sync, scl_rise, scl_fall;
  logic sda_sync, sda_rise, sda_fall;
  logic scl_held_high, start_cond, stop_cond, contention_raw;

  bus_state_e              state_q, state_d;
  logic                    start_q, start_d, rstart_q, rstart_d, stop_q, stop_d;
  logic [TimerWidth-1:0]   idle_cnt_q, idle_cnt_d;
  logic                    cont_q, cont_d;
  logic [ContCntWidth-1:0] cont_cnt_q, cont_cnt_d;
  logic [NumAgents-1:0]    arb_cond_q, arb_cond_d, arb_q, arb_d;

  // Wired-AND with pull-up: any enabled agent driving 0 wins.
  assign scl_o = ~|(agent_scl_en_i & ~agent_scl_i);
  assign sda_o = ~|(agent_sda_en_i & ~agent_sda_i);

  assign contention_raw =
      (|(agent_scl_en_i & agent_scl_i) & |(agent_scl_en_i & ~agent_scl_i)) |
      (|(agent_sda_en_i & agent_sda_i) & |(agent_sda_en_i & ~agent_sda_i));

  i3c_bus_line_sync #(.SyncStages(SyncStages)) u_scl_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .line_i (scl_o),
    .sync_o (scl_sync),
    .rise_o (scl_rise),
    .fall_o (scl_fall)
  );

  i3c_bus_line_sync #(.SyncStages(SyncStages)) u_sda_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .line_i (sda_o),
    .sync_o (sda_sync),
    .rise_o (sda_rise),
    .fall_o (sda_fall)
  );

  // SCL high now and in the previous cycle (no SCL edge this cycle).
  assign scl_held_high = scl_sync & ~scl_rise & ~scl_fall;
  assign start_cond    = sda_fall & scl_held_high;
  assign stop_cond     = sda_rise & scl_held_high;

  always_comb begin
    state_d  = state_q;
    start_d  = 1'b0;
    rstart_d = 1'b0;
    stop_d   = 1'b0;
    if (start_cond) begin
      start_d  = (state_q == FREE);
      rstart_d = (state_q == BUSY);
      state_d  = BUSY;
    end else if (stop_cond) begin
      stop_d  = 1'b1;
      state_d = FREE;
    end

    idle_cnt_d = idle_cnt_q;
    if ((state_q == BUSY) || !scl_sync || !sda_sync) begin
      idle_cnt_d = '0;
    end else if (!(&idle_cnt_q)) begin
      idle_cnt_d = idle_cnt_q + 1'b1;
    end

    cont_d     = contention_raw;
    cont_cnt_d = cont_cnt_q;
    if (contention_cnt_clr_i) begin
      cont_cnt_d = '0;
    end else if (cont_q && !(&cont_cnt_q)) begin
      cont_cnt_d = cont_cnt_q + 1'b1;
    end

    // Agent expects SDA high (driving 1, or released while clocking) yet SDA is low.
    for (int i = 0; i < int'(NumAgents); i++) begin
      arb_cond_d[i] = ((agent_sda_en_i[i] & agent_sda_i[i]) |
                       (~agent_sda_en_i[i] & agent_scl_en_i[i])) & ~sda_o & scl_o;
    end
    arb_d = arb_cond_d & ~arb_cond_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= FREE;
      start_q    <= 1'b0;
      rstart_q   <= 1'b0;
      stop_q     <= 1'b0;
      idle_cnt_q <= '0;
      cont_q     <= 1'b0;
      cont_cnt_q <= '0;
      arb_cond_q <= '0;
      arb_q      <= '0;
    end else begin
      state_q    <= state_d;
      start_q    <= start_d;
      rstart_q   <= rstart_d;
      stop_q     <= stop_d;
      idle_cnt_q <= idle_cnt_d;
      cont_q     <= cont_d;
      cont_cnt_q <= cont_cnt_d;
      arb_cond_q <= arb_cond_d;
      arb_q      <= arb_d;
    end
  end

  assign scl_sync_o         = scl_sync;
  assign sda_sync_o         = sda_sync;
  assign start_det_o        = start_q;
  assign rstart_det_o       = rstart_q;
  assign stop_det_o         = stop_q;
  assign bus_busy_o         = (state_q == BUSY);
  assign bus_free_o         = (idle_cnt_q >= t_buf_i);
  assign bus_idle_o         = (idle_cnt_q >= t_idle_i);
  assign event_contention_o = cont_q;
  assign contention_cnt_o   = cont_cnt_q;
  assign arb_lost_o         = arb_q;

endmodule

`default_nettype wire

// File: tb/tb_i3c_multi_agent_bus.sv
// ============================================================================
// Module  : tb_i3c_multi_agent_bus
// Brief   : Scoreboard bench for i3c_multi_agent_bus (2 agents, 2 sync stages).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_i3c_multi_agent_bus;

  localparam int S_SCL = 0, S_SDA = 1, S_SCLS = 2, S_SDAS = 3, S_START = 4,
                 S_RSTART = 5, S_STOP = 6, S_BUSY = 7, S_FREE = 8, S_IDLE = 9,
                 S_CONT = 10, S_CCNT = 11, S_ARB = 12;

  logic       clk, rst_n;
  logic [1:0] scl, scl_en, sda, sda_en, arb_lost;
  logic       scl_o, sda_o, scl_sync, sda_sync;
  logic [15:0] t_buf, t_idle;
  logic       start_det, rstart_det, stop_det, busy, free_o, idle_o, cont, clr;
  logic [7:0] ccnt;

  typedef struct {
    string       tag;
    int          sig;
    int          due;
    logic [31:0] exp;
  } sb_t;

  sb_t sbq[$];
  int  cyc = 0;
  int  errors = 0;
  int  checks = 0;

  i3c_multi_agent_bus #(
    .NumAgents(2), .SyncStages(2), .TimerWidth(16), .ContCntWidth(8)
  ) dut (
    .clk_i                (clk),
    .rst_ni               (rst_n),
    .agent_scl_i          (scl),
    .agent_scl_en_i       (scl_en),
    .agent_sda_i          (sda),
    .agent_sda_en_i       (sda_en),
    .scl_o                (scl_o),
    .sda_o                (sda_o),
    .scl_sync_o           (scl_sync),
    .sda_sync_o           (sda_sync),
    .t_buf_i              (t_buf),
    .t_idle_i             (t_idle),
    .start_det_o          (start_det),
    .rstart_det_o         (rstart_det),
    .stop_det_o           (stop_det),
    .bus_busy_o           (busy),
    .bus_free_o           (free_o),
    .bus_idle_o           (idle_o),
    .event_contention_o   (cont),
    .contention_cnt_o     (ccnt),
    .contention_cnt_clr_i (clr),
    .arb_lost_o           (arb_lost)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [31:0] observe(input int s);
    case (s)
      S_SCL:    return {31'd0, scl_o};
      S_SDA:    return {31'd0, sda_o};
      S_SCLS:   return {31'd0, scl_sync};
      S_SDAS:   return {31'd0, sda_sync};
      S_START:  return {31'd0, start_det};
      S_RSTART: return {31'd0, rstart_det};
      S_STOP:   return {31'd0, stop_det};
      S_BUSY:   return {31'd0, busy};
      S_FREE:   return {31'd0, free_o};
      S_IDLE:   return {31'd0, idle_o};
      S_CONT:   return {31'd0, cont};
      S_CCNT:   return {24'd0, ccnt};
      S_ARB:    return {30'd0, arb_lost};
      default:  return 32'hdead_beef;
    endcase
  endfunction

  // Expect signal s to equal v, d cycles from now.
  task automatic exp_at(input int d, input int s, input logic [31:0] v, input string tag);
    sb_t e;
    e.tag = tag;
    e.sig = s;
    e.due = cyc + d;
    e.exp = v;
    sbq.push_back(e);
  endtask

  always @(negedge clk) begin
    for (int i = sbq.size() - 1; i >= 0; i--) begin
      if (sbq[i].due == cyc) begin
        check_eq(sbq[i].tag, observe(sbq[i].sig), sbq[i].exp);
        sbq.delete(i);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0;
    scl = '0; scl_en = '0; sda = '0; sda_en = '0;
    t_buf = 16'd5; t_idle = 16'd10;

    tick(2);
    exp_at(0, S_SCLS, 1, "rst_scl_sync");
    exp_at(0, S_SDAS, 1, "rst_sda_sync");
    exp_at(0, S_BUSY, 0, "rst_busy");
    exp_at(0, S_CCNT, 0, "rst_ccnt");
    exp_at(0, S_ARB,  0, "rst_arb");
    exp_at(0, S_FREE, 0, "rst_free");
    rst_n = 1'b1;
    exp_at(0, S_SCL, 1, "idle_scl");
    exp_at(0, S_SDA, 1, "idle_sda");
    exp_at(4, S_FREE, 0, "free_early");
    exp_at(5, S_FREE, 1, "free_at5");
    exp_at(9, S_IDLE, 0, "idle_early");
    exp_at(10, S_IDLE, 1, "idle_at10");
    exp_at(15, S_BUSY, 0, "idle_busy");

    tick(20);  // START: agent0 pulls SDA low, SCL pulled up
    sda_en[0] = 1'b1; sda[0] = 1'b0;
    exp_at(0, S_SDA, 0, "start_sda_o");
    exp_at(2, S_SDAS, 0, "start_sda_sync");
    exp_at(2, S_START, 0, "start_early");
    exp_at(3, S_START, 1, "start_pulse");
    exp_at(4, S_START, 0, "start_one_cycle");
    exp_at(3, S_BUSY, 1, "start_busy");
    exp_at(3, S_FREE, 0, "start_not_free");

    tick(8);   // SCL low, then SDA rise while SCL low (ignored)
    scl_en[0] = 1'b1; scl[0] = 1'b0;
    tick(4);
    sda_en[0] = 1'b0;
    exp_at(3, S_STOP, 0, "rise_scl_low_ignored");
    exp_at(3, S_BUSY, 1, "busy_scl_low");
    tick(4);
    scl_en[0] = 1'b0;
    tick(4);   // repeated START
    sda_en[0] = 1'b1; sda[0] = 1'b0;
    exp_at(3, S_RSTART, 1, "rstart_pulse");
    exp_at(3, S_START, 0, "rstart_no_start");
    exp_at(3, S_BUSY, 1, "rstart_busy");
    exp_at(4, S_RSTART, 0, "rstart_one_cycle");

    tick(8);   // STOP
    sda_en[0] = 1'b0;
    exp_at(3, S_STOP, 1, "stop_pulse");
    exp_at(4, S_STOP, 0, "stop_one_cycle");
    exp_at(3, S_RSTART, 0, "stop_no_rstart");
    exp_at(3, S_BUSY, 0, "stop_busy");
    exp_at(7, S_FREE, 0, "stop_free_early");
    exp_at(8, S_FREE, 1, "stop_free_at5");

    tick(20);  // contention on SDA for 3 cycles
    sda_en = 2'b11; sda = 2'b01;
    exp_at(0, S_CONT, 0, "cont_lag");
    exp_at(1, S_CONT, 1, "cont_c1");
    exp_at(3, S_CONT, 1, "cont_c3");
    exp_at(4, S_CONT, 0, "cont_end");
    exp_at(4, S_CCNT, 3, "ccnt_3");
    exp_at(6, S_CCNT, 3, "ccnt_hold");
    exp_at(1, S_ARB, 2'b01, "arb_push_pull");
    exp_at(2, S_ARB, 2'b00, "arb_push_pull_once");
    tick(3);
    sda_en = 2'b00;

    tick(7);   // sustained contention, clear, saturation
    sda_en = 2'b11; sda = 2'b01;
    tick(5);
    exp_at(0, S_CCNT, 7, "ccnt_before_clr");
    exp_at(1, S_CCNT, 0, "ccnt_clr");
    exp_at(2, S_CCNT, 1, "ccnt_after_clr");
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    exp_at(300, S_CCNT, 255, "ccnt_saturate");
    tick(300);
    sda_en = 2'b00;

    tick(14);  // arbitration loss: agent0 clocks with SDA released
    scl_en = 2'b01; scl = 2'b01;
    sda_en = 2'b10; sda = 2'b00;
    exp_at(0, S_ARB, 0, "arb_lag");
    exp_at(1, S_ARB, 2'b01, "arb_lost0");
    exp_at(2, S_ARB, 0, "arb_once");
    exp_at(5, S_ARB, 0, "arb_held");
    exp_at(1, S_CONT, 0, "arb_no_cont");
    tick(5);
    exp_at(4, S_BUSY, 1, "pre_rst_busy");
    exp_at(4, S_CCNT, 255, "pre_rst_ccnt");
    exp_at(4, S_SDAS, 0, "pre_rst_sda_sync");
    tick(5);

    rst_n = 1'b0;  // asynchronous reset mid-transfer
    exp_at(0, S_BUSY, 0, "arst_busy");
    exp_at(0, S_CCNT, 0, "arst_ccnt");
    exp_at(0, S_SCLS, 1, "arst_scl_sync");
    exp_at(0, S_SDAS, 1, "arst_sda_sync");
    exp_at(0, S_FREE, 0, "arst_free");
    exp_at(0, S_SDA, 0, "arst_sda_o");
    tick(2);
    rst_n = 1'b1;
    tick(5);

    if (sbq.size() != 0) check_eq("sb_pending", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
